button_press_classifier: RTL and testbench

- Front-end for a push button feeding the stopwatch control FSMs.
- Samples the raw asynchronous-to-logic button on a slow sample tick and debounces it with hysteresis.
- Classifies each press as short or long and emits one-clock-wide event pulses.
- Replaces the separate debounce / one-pulse / long-push chain with a single block on one clock domain.

---
 rtl/button_press_classifier_if.sv | 30 +++
 rtl/button_press_classifier.sv | 146 ++++++++++++++
 tb/tb_button_press_classifier.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/button_press_classifier_if.sv
// Button front-end bundle: tick and raw button in, debounced level and press events out.
interface button_press_classifier_if;
    logic tick;
    logic btn_in;
    logic btn_level;
    logic short_pulse;
    logic long_pulse;
    logic holding;
    logic repeat_pulse;

    modport master (
        output tick,
        output btn_in,
        input  btn_level,
        input  short_pulse,
        input  long_pulse,
        input  holding,
        input  repeat_pulse
    );

    modport slave (
        input  tick,
        input  btn_in,
        output btn_level,
        output short_pulse,
        output long_pulse,
        output holding,
        output repeat_pulse
    );
endinterface

// File: rtl/button_press_classifier.sv
// Push-button front-end: tick-sampled hysteresis debounce plus short/long press classification.
// Define BUTTON_AUTO_REPEAT_EN to add auto-repeat pulses while a long press is held.
module button_press_classifier #(
    parameter int DB_LEN       = 4,
    parameter int LONG_TICKS   = 200,
    parameter int CNT_W        = 8,
    parameter int REPEAT_TICKS = 25
) (
    input  logic                     clk,
    input  logic                     rst_n,
    button_press_classifier_if.slave bus
);
    // state     | meaning
    // IDLE      | debounced level low, waiting for a press
    // PRESS     | held, counting ticks toward the long threshold
    // LONG_HELD | long threshold reached and button still held
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS     = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    if (DB_LEN < 2 || DB_LEN > 16) begin : g_chk_db_len
        $error("DB_LEN must be in 2..16");
    end
    if ((2 ** CNT_W) <= LONG_TICKS || LONG_TICKS < 1) begin : g_chk_cnt_w
        $error("CNT_W too narrow for LONG_TICKS");
    end
    if (REPEAT_TICKS < 1) begin : g_chk_repeat
        $error("REPEAT_TICKS must be at least 1");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_TICKS - 1);

    state_t            state;
    logic [DB_LEN-1:0] shift_q;
    logic [DB_LEN-1:0] shift_next;
    logic              level_q;
    logic              db_next;
    logic [CNT_W-1:0]  hold_cnt;
    logic              short_q;
    logic              long_q;
    logic              holding_q;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS - 1);

    logic [REP_W-1:0]  rep_cnt;
    logic              repeat_q;
`endif

    assign shift_next = {shift_q[DB_LEN-2:0], bus.btn_in};

    // Hysteresis: only a full run of equal samples moves the level.
    always_comb begin
        db_next = level_q;
        if (&shift_next) begin
            db_next = 1'b1;
        end else if (~|shift_next) begin
            db_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_q   <= '0;
            level_q   <= 1'b0;
            hold_cnt  <= '0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            holding_q <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            rep_cnt   <= '0;
            repeat_q  <= 1'b0;
`endif
        end else begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
            repeat_q <= 1'b0;
`endif
            if (bus.tick) begin
                shift_q <= shift_next;
                level_q <= db_next;
                case (state)
                    IDLE: begin
                        if (db_next) begin
                            state    <= PRESS;
                            hold_cnt <= '0;
                        end
                    end
                    PRESS: begin
                        // Release wins over the threshold on the same tick.
                        if (!db_next) begin
                            state   <= IDLE;
                            short_q <= 1'b1;
                        end else if (hold_cnt == HOLD_LAST) begin
                            state     <= LONG_HELD;
                            long_q    <= 1'b1;
                            holding_q <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                            rep_cnt   <= '0;
`endif
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    LONG_HELD: begin
                        if (!db_next) begin
                            state     <= IDLE;
                            holding_q <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
                            rep_cnt   <= '0;
`endif
                        end
`ifdef BUTTON_AUTO_REPEAT_EN
                        else if (rep_cnt == REP_LAST) begin
                            rep_cnt  <= '0;
                            repeat_q <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
`endif
                    end
                    default: begin
                        state     <= IDLE;
                        holding_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.short_pulse = short_q;
    assign bus.long_pulse  = long_q;
    assign bus.holding     = holding_q;
`ifdef BUTTON_AUTO_REPEAT_EN
    assign bus.repeat_pulse = repeat_q;
`else
    assign bus.repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench for button_press_classifier (DB_LEN=4, LONG_TICKS=10, REPEAT_TICKS=3, tick every 4 clk).
module tb_button_press_classifier;
    localparam logic [6:0] LR = 7'b0000001; // level rise
    localparam logic [6:0] LF = 7'b0000010; // level fall
    localparam logic [6:0] SH = 7'b0000100;
    localparam logic [6:0] LG = 7'b0001000;
    localparam logic [6:0] RP = 7'b0010000;
    localparam logic [6:0] HR = 7'b0100000; // holding rise
    localparam logic [6:0] HF = 7'b1000000; // holding fall

    typedef struct {
        logic [6:0] ev;
        int         tick;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tick_cnt = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic rst_at_edge = 1'b1;
    logic prev_level = 1'b0;
    logic prev_hold = 1'b0;
    exp_t exp_q[$];

    button_press_classifier_if bus ();

    button_press_classifier #(
        .DB_LEN      (4),
        .LONG_TICKS  (10),
        .CNT_W       (8),
        .REPEAT_TICKS(3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus.tick = 1'b1;
            @(negedge clk);
            bus.tick = 1'b0;
        end
    end

    always @(posedge clk) begin
        rst_at_edge = !rst_n;
        if (bus.tick) tick_cnt++;
    end

    // Monitor: every cycle with an edge or pulse is one event checked against the queue head.
    always @(negedge clk) begin
        logic [6:0] ev;
        exp_t       e;
        ev = '0;
        if (!rst_at_edge) begin
            if (bus.btn_level && !prev_level) ev |= LR;
            if (!bus.btn_level && prev_level) ev |= LF;
            if (bus.short_pulse)              ev |= SH;
            if (bus.long_pulse)               ev |= LG;
            if (bus.repeat_pulse)             ev |= RP;
            if (bus.holding && !prev_hold)    ev |= HR;
            if (!bus.holding && prev_hold)    ev |= HF;
            if (ev != '0) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event: got ev=%b at tick %0d, required no event", ev, tick_cnt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.ev !== ev || e.tick != tick_cnt) begin
                        n_err++;
                        $display("FAIL %s: got ev=%b at tick %0d, required ev=%b at tick %0d",
                                 e.name, ev, tick_cnt, e.ev, e.tick);
                    end
                end
            end
        end
        prev_level = bus.btn_level;
        prev_hold  = bus.holding;
    end

    task automatic push(input logic [6:0] ev, input int t, input string name);
        exp_t e;
        e.ev   = ev;
        e.tick = t;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic hold(input logic v, input int n);
        bus.btn_in = v;
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!bus.tick);
        end
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_btn_level"},    bus.btn_level,    1'b0);
        check({tag, "_holding"},      bus.holding,      1'b0);
        check({tag, "_short_pulse"},  bus.short_pulse,  1'b0);
        check({tag, "_long_pulse"},   bus.long_pulse,   1'b0);
        check({tag, "_repeat_pulse"}, bus.repeat_pulse, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d events still pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        rst_n      = 1'b0;
        bus.btn_in = 1'b1;
        repeat (10) @(negedge clk);
        check_cleared("reset");

        // Press held through reset must re-accumulate four ones.
        rst_n = 1'b1;
        b = tick_cnt;
        push(LR, b + 4, "rst_hold_rise");
        push(LF | SH, b + 10, "rst_hold_short");
        hold(1'b1, 6);
        hold(1'b0, 6);

        // Bounce of three samples: nothing expected.
        hold(1'b1, 3);
        hold(1'b0, 6);

        b = tick_cnt;
        push(LR, b + 4, "short_rise");
        push(LF | SH, b + 12, "short_release");
        hold(1'b1, 8);
        hold(1'b0, 6);

        b = tick_cnt;
        push(LR, b + 4, "long_rise");
        push(LG | HR, b + 14, "long_pulse");
`ifdef BUTTON_AUTO_REPEAT_EN
        push(RP, b + 17, "repeat_1");
        push(RP, b + 20, "repeat_2");
        push(RP, b + 23, "repeat_3");
`endif
        push(LF | HF, b + 24, "long_release");
        hold(1'b1, 20);
        hold(1'b0, 6);

        // Release lands exactly on the threshold tick: short wins.
        b = tick_cnt;
        push(LR, b + 4, "thresh_rise");
        push(LF | SH, b + 14, "thresh_short");
        hold(1'b1, 10);
        hold(1'b0, 6);

        // One tick later the threshold is reached first.
        b = tick_cnt;
        push(LR, b + 4, "thresh1_rise");
        push(LG | HR, b + 14, "thresh1_long");
        push(LF | HF, b + 15, "thresh1_release");
        hold(1'b1, 11);
        hold(1'b0, 6);

        // Reset in PRESS with hold_cnt at 5 aborts silently.
        b = tick_cnt;
        push(LR, b + 4, "midrst_rise");
        hold(1'b1, 9);
        rst_n = 1'b0;
        @(negedge clk);
        check_cleared("midrst");
        rst_n = 1'b1;
        b = tick_cnt;
        push(LR, b + 4, "midrst_redetect");
        push(LF | SH, b + 10, "midrst_short");
        hold(1'b1, 6);
        hold(1'b0, 6);

        repeat (8) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_events: got %0d events outstanding, required 0 (next %s)",
                     exp_q.size(), exp_q[0].name);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
